// File: rtl/isp_ol_scheduler_pkg.sv
// rtl/isp_ol_scheduler_pkg.sv - shared states, entry-type codes and field positions for the object-list scheduler
package isp_ol_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    ISSUE,
    WAIT_POLY,
    FINISH
  } state_t;

  localparam logic [2:0] TYPE_ARRAY = 3'b100;
  localparam logic [2:0] TYPE_QUAD  = 3'b101;
  localparam logic [2:0] TYPE_RSVD  = 3'b110;
  localparam logic [2:0] TYPE_LINK  = 3'b111;

  // Bit 31 clear marks a triangle strip; otherwise [31:29] is the entry type.
  localparam int STRIP_BIT     = 31;
  localparam int TYPE_MSB      = 31;
  localparam int TYPE_LSB      = 29;
  localparam int MASK_MSB      = 30;
  localparam int MASK_LSB      = 25;
  localparam int LINK_EOL_BIT  = 28;
  localparam int LINK_ADDR_MSB = 23;
  localparam int LINK_ADDR_LSB = 2;
  localparam int PARAM_IDX_MSB = 20;

endpackage

// File: rtl/isp_ol_scheduler.sv
// rtl/isp_ol_scheduler.sv - object-list walker feeding the ISP parser; optional poly watchdog via ISP_OLS_WATCHDOG_EN
module isp_ol_scheduler
  import isp_ol_scheduler_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] ol_addr,
  input  logic [ADDR_W-1:0] param_base,
  output logic              busy,
  output logic              done,
  output logic [15:0]       poly_count,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [31:0]       vram_din,
  output logic [31:0]       opb_word,
  output logic [ADDR_W-1:0] poly_addr,
  output logic              render_poly,
  input  logic              poly_drawn,
`ifdef ISP_OLS_WATCHDOG_EN
  output logic              wdog_err,
`endif
  input  logic              isp_vram_rd,
  input  logic [ADDR_W-1:0] isp_vram_addr
);

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  state_t            state;
  logic [ADDR_W-1:0] pointer;
  logic [ADDR_W-1:0] param_reg;

  logic [2:0]        entry_type;
  logic [23:0]       link_target;
  logic [ADDR_W-1:0] next_pointer;

`ifdef ISP_OLS_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
`endif

  assign entry_type   = opb_word[TYPE_MSB:TYPE_LSB];
  assign link_target  = {opb_word[LINK_ADDR_MSB:LINK_ADDR_LSB], 2'b00};
  assign next_pointer = pointer + ADDR_W'(4);

  // The parser owns the VRAM port only while a polygon is being drawn.
  always_comb begin
    vram_rd   = 1'b0;
    vram_addr = pointer;
    if (state == WAIT_POLY) begin
      vram_rd   = isp_vram_rd;
      vram_addr = isp_vram_addr;
    end else if (state == FETCH) begin
      vram_rd   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      render_poly <= 1'b0;
      poly_count  <= '0;
      opb_word    <= '0;
      poly_addr   <= '0;
      pointer     <= '0;
      param_reg   <= '0;
`ifdef ISP_OLS_WATCHDOG_EN
      wdog_cnt    <= '0;
      wdog_err    <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      render_poly <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pointer    <= ol_addr;
            param_reg  <= param_base;
            poly_count <= '0;
            busy       <= 1'b1;
`ifdef ISP_OLS_WATCHDOG_EN
            wdog_err   <= 1'b0;
`endif
            state      <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          opb_word <= vram_din;
          state    <= DECODE;
        end
        DECODE: begin
          // Issue outputs are registered here so render_poly is high exactly during ISSUE.
          if ((!opb_word[STRIP_BIT] && (opb_word[MASK_MSB:MASK_LSB] != '0)) ||
              (opb_word[STRIP_BIT] && (entry_type == TYPE_ARRAY || entry_type == TYPE_QUAD))) begin
            poly_addr   <= param_reg + ADDR_W'({opb_word[PARAM_IDX_MSB:0], 2'b00});
            render_poly <= 1'b1;
            if (poly_count != 16'hFFFF)
              poly_count <= poly_count + 16'd1;
            state       <= ISSUE;
          end else if (opb_word[STRIP_BIT] && entry_type == TYPE_LINK) begin
            if (opb_word[LINK_EOL_BIT]) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              pointer <= ADDR_W'(link_target);
              state   <= FETCH;
            end
          end else begin
            pointer <= next_pointer;
            state   <= FETCH;
          end
        end
        ISSUE: begin
`ifdef ISP_OLS_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
          state <= WAIT_POLY;
        end
        WAIT_POLY: begin
          if (poly_drawn) begin
            pointer <= next_pointer;
            state   <= FETCH;
          end
`ifdef ISP_OLS_WATCHDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            wdog_err <= 1'b1;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_ol_scheduler.sv
// tb/tb_isp_ol_scheduler.sv - scoreboard bench for isp_ol_scheduler (watchdog case under ISP_OLS_WATCHDOG_EN)
module tb_isp_ol_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] ol_addr = '0;
  logic [23:0] param_base = '0;
  logic        busy, done, vram_rd, render_poly;
  logic [15:0] poly_count;
  logic [23:0] vram_addr, poly_addr;
  logic [31:0] vram_din = '0;
  logic [31:0] opb_word;
  logic        poly_drawn = 1'b0;
  logic        isp_vram_rd = 1'b0;
  logic [23:0] isp_vram_addr = '0;
`ifdef ISP_OLS_WATCHDOG_EN
  logic        wdog_err;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [23:0]];
  logic [23:0] exp_fetch [$];
  logic [23:0] exp_poly [$];
  logic [15:0] exp_done [$];

  isp_ol_scheduler #(.ADDR_W(24), .WDOG_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ol_addr(ol_addr),
    .param_base(param_base), .busy(busy), .done(done), .poly_count(poly_count),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_din(vram_din),
    .opb_word(opb_word), .poly_addr(poly_addr), .render_poly(render_poly),
    .poly_drawn(poly_drawn),
`ifdef ISP_OLS_WATCHDOG_EN
    .wdog_err(wdog_err),
`endif
    .isp_vram_rd(isp_vram_rd), .isp_vram_addr(isp_vram_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (vram_rd) vram_din <= mem.exists(vram_addr) ? mem[vram_addr] : 32'hF0000000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: scheduler fetches, render requests and done pulses against the queues.
  always @(negedge clock) begin
    if (reset_n) begin
      if (vram_rd && !isp_vram_rd) begin
        if (exp_fetch.size() == 0) chk("fetch_unexpected", {8'h0, vram_addr}, 32'hFFFFFFFF);
        else chk("fetch_addr", {8'h0, vram_addr}, {8'h0, exp_fetch.pop_front()});
      end
      if (render_poly) begin
        if (exp_poly.size() == 0) chk("render_unexpected", {8'h0, poly_addr}, 32'hFFFFFFFF);
        else chk("poly_addr", {8'h0, poly_addr}, {8'h0, exp_poly.pop_front()});
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", {16'h0, poly_count}, 32'hFFFFFFFF);
        else chk("done_poly_count", {16'h0, poly_count}, {16'h0, exp_done.pop_front()});
      end
    end
  end

  task automatic do_start(input logic [23:0] a, input logic [23:0] pb);
    @(posedge clock); #1;
    ol_addr = a; param_base = pb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_render();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (render_poly) begin ok = 1'b1; break; end
    end
    if (!ok) chk("render_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_drawn();
    @(posedge clock); #1;
    @(posedge clock); #1 poly_drawn = 1'b1;
    @(posedge clock); #1 poly_drawn = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic walk_single_strip();
    mem.delete();
    mem[24'h001000] = 32'h02000010;
    mem[24'h001004] = 32'hF0000000;
    exp_fetch.push_back(24'h001000); exp_fetch.push_back(24'h001004);
    exp_poly.push_back(24'h200040);
    exp_done.push_back(16'd1);
    do_start(24'h001000, 24'h200000);
    wait_render();
    pulse_drawn();
    wait_idle();
    chk("count_hold", {16'h0, poly_count}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_vram_rd", {31'h0, vram_rd}, 32'h0);
    chk("rst_outputs", {8'h0, poly_addr} | opb_word | {16'h0, poly_count}, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;

    walk_single_strip();

    mem.delete();
    mem[24'h001000] = 32'hE0002000;
    mem[24'h002000] = 32'h80000000;
    mem[24'h002004] = 32'hF0000000;
    exp_fetch.push_back(24'h001000); exp_fetch.push_back(24'h002000);
    exp_fetch.push_back(24'h002004);
    exp_poly.push_back(24'h100000);
    exp_done.push_back(16'd1);
    do_start(24'h001000, 24'h100000);
    wait_render();
    pulse_drawn();
    wait_idle();

    mem.delete();
    mem[24'h001000] = 32'h00000000;
    mem[24'h001004] = 32'hC0000000;
    mem[24'h001008] = 32'hF0000000;
    exp_fetch.push_back(24'h001000); exp_fetch.push_back(24'h001004);
    exp_fetch.push_back(24'h001008);
    exp_done.push_back(16'd0);
    do_start(24'h001000, 24'h200000);
    wait_idle();

    @(posedge clock); #1 poly_drawn = 1'b1;
    @(posedge clock); #1 poly_drawn = 1'b0;
    @(negedge clock);
    chk("drawn_idle_busy", {31'h0, busy}, 32'h0);
    chk("drawn_idle_vram_rd", {31'h0, vram_rd}, 32'h0);

    mem.delete();
    mem[24'hFFFFFC] = 32'hA0000003;
    mem[24'h000000] = 32'hF0000000;
    exp_fetch.push_back(24'hFFFFFC); exp_fetch.push_back(24'h000000);
    exp_poly.push_back(24'h20000C);
    exp_done.push_back(16'd1);
    do_start(24'hFFFFFC, 24'h200000);
    wait_render();
    @(posedge clock); #1;
    isp_vram_rd = 1'b1; isp_vram_addr = 24'h003004;
    #1;
    chk("mux_vram_addr", {8'h0, vram_addr}, 32'h00003004);
    chk("mux_vram_rd", {31'h0, vram_rd}, 32'h1);
    chk("opb_word_held", opb_word, 32'hA0000003);
    @(posedge clock); #1;
    isp_vram_rd = 1'b0; ol_addr = 24'h005000; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk("start_ignored_busy", {31'h0, busy}, 32'h1);
    poly_drawn = 1'b1;
    @(posedge clock); #1 poly_drawn = 1'b0;
    wait_idle();

    mem.delete();
    mem[24'h001000] = 32'hA0000003;
    exp_fetch.push_back(24'h001000);
    exp_poly.push_back(24'h20000C);
    do_start(24'h001000, 24'h200000);
    wait_render();
    @(posedge clock); #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {30'h0, busy, done}, 32'h0);
    chk("rst_mid_strobes", {30'h0, render_poly, vram_rd}, 32'h0);
    chk("rst_mid_poly_count", {16'h0, poly_count}, 32'h0);
    chk("rst_mid_opb_word", opb_word, 32'h0);
    chk("rst_mid_addrs", {8'h0, poly_addr | vram_addr}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    walk_single_strip();

`ifdef ISP_OLS_WATCHDOG_EN
    begin
      int n = 0;
      bit seen = 1'b0;
      mem.delete();
      mem[24'h001000] = 32'hA0000003;
      exp_fetch.push_back(24'h001000);
      exp_poly.push_back(24'h20000C);
      exp_done.push_back(16'd1);
      do_start(24'h001000, 24'h200000);
      wait_render();
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        n++;
        if (done) begin seen = 1'b1; break; end
      end
      chk("wdog_done_seen", {31'h0, seen}, 32'h1);
      chk("wdog_latency", n, 32'd17);
      chk("wdog_err", {31'h0, wdog_err}, 32'h1);
      wait_idle();
    end
`endif

    repeat (3) @(negedge clock);
    chk("fetch_queue_empty", exp_fetch.size(), 32'h0);
    chk("poly_queue_empty", exp_poly.size(), 32'h0);
    chk("done_queue_empty", exp_done.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
